data_ram_sync: RTL and testbench

DATA_RAM_SYNC -- requirements
Module: data_ram_sync

---
 rtl/dataram_pkg.sv | 34 +++
 rtl/load_extend.sv | 38 +++
 rtl/data_ram_sync.sv | 136 +++++++++++++
 tb/tb_data_ram_sync.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dataram_pkg.sv
// Shared types and lane-mask helpers for the data RAM and its load path.
// Combinational definitions only; no latency, no flow control.
// Used by data_ram_sync and load_extend.
package dataram_pkg;

    typedef enum logic [1:0] {
        ACC_WORD = 2'b00,
        ACC_HALF = 2'b01,
        ACC_BYTE = 2'b10,
        ACC_RSVD = 2'b11
    } acc_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [3:0] LANES_NONE    = 4'b0000;
    localparam logic [3:0] LANES_ALL     = 4'b1111;
    localparam logic [3:0] LANES_HALF_LO = 4'b0011;
    localparam logic [3:0] LANES_HALF_HI = 4'b1100;
    localparam logic [3:0] LANES_BYTE0   = 4'b0001;

    // Offset bits below the access size are ignored; the caller decides rejection.
    function automatic logic [3:0] lane_mask(input acc_t acc, input logic [1:0] off);
        case (acc)
            ACC_WORD: return LANES_ALL;
            ACC_HALF: return off[1] ? LANES_HALF_HI : LANES_HALF_LO;
            ACC_BYTE: return LANES_BYTE0 << off;
            default:  return LANES_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a 32-bit word and sign- or zero-extends it.
// Purely combinational, zero latency; no flow control.
// Word and reserved accesses pass the word through unchanged.
module load_extend
    import dataram_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  acc,
    input  logic [1:0]  offset,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (acc_t'(acc))
            ACC_HALF: result = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            ACC_BYTE: result = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/data_ram_sync.sv
// Byte-addressable 32-bit data RAM with word/half/byte access and post-reset clear sweep.
// Loads: 1-cycle latency to Data_out/rd_valid; stores: no response. req_ready low only while clearing.
// Optional alignment checking via macro DATARAM_ALIGN_CHECK_EN.
module data_ram_sync
    import dataram_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write_en,
    input  logic [1:0]        AccessType,
    input  logic              load_unsigned,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Data_out,
    output logic              rd_valid,
    output logic              misalign_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic [31:0]       mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;

    acc_t              acc;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        off;
    logic              accept, reject, do_store, do_load;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
    logic [31:0]       rd_word, ld_result;

    assign acc  = acc_t'(AccessType);
    assign widx = addr[ADDR_W+1:2];
    assign off  = addr[1:0];

`ifdef DATARAM_ALIGN_CHECK_EN
    assign reject = (acc == ACC_RSVD)
                 || (acc == ACC_HALF && off[0])
                 || (acc == ACC_WORD && off != 2'b00);
`else
    assign reject = (acc == ACC_RSVD);
`endif

    assign accept   = req_valid && req_ready;
    assign do_store = accept && write_en && !reject;
    assign do_load  = accept && !write_en && !reject;
    assign wmask    = lane_mask(acc, off);

    always_comb begin
        wdata = Data_in;
        case (acc)
            ACC_BYTE: wdata = {4{Data_in[7:0]}};
            ACC_HALF: wdata = {2{Data_in[15:0]}};
            default:  wdata = Data_in;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: req_ready = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Array has no reset; reset only blocks writes on the edge it is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else if (do_store) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];

    load_extend u_load_extend (
        .word          (rd_word),
        .acc           (AccessType),
        .offset        (off),
        .load_unsigned (load_unsigned),
        .result        (ld_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_load;
            if (do_load) Data_out <= ld_result;
        end
    end

`ifdef DATARAM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && reject;
    end

    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_sync.sv
// Directed table-driven bench for data_ram_sync (ADDR_W=6, CLEAR_ON_RST=1).
// Expectations follow DATARAM_ALIGN_CHECK_EN if the bench is built with it.
module tb_data_ram_sync;

`ifdef DATARAM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, R = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        write_en = 1'b0;
    logic [1:0]  AccessType = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] Data_in = '0;
    logic [31:0] Data_out;
    logic        rd_valid;
    logic        misalign_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    data_ram_sync #(.ADDR_W(6), .CLEAR_ON_RST(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .write_en      (write_en),
        .AccessType    (AccessType),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .Data_in       (Data_in),
        .Data_out      (Data_out),
        .rd_valid      (rd_valid),
        .misalign_err  (misalign_err)
    );

    typedef struct {
        logic        vld;
        logic        we;
        logic [1:0]  acc;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] din;
        logic        exp_rd;
        logic        exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic we, input logic [1:0] acc,
                         input logic uns, input logic [7:0] a, input logic [31:0] d);
        req_valid     = vld;
        write_en      = we;
        AccessType    = acc;
        load_unsigned = uns;
        addr          = a;
        Data_in       = d;
    endtask

    task automatic add(input logic vld, input logic we, input logic [1:0] acc, input logic uns,
                       input logic [7:0] a, input logic [31:0] d, input logic erd,
                       input logic eerr, input logic [31:0] edout);
        vec_t v;
        v.vld = vld; v.we = we; v.acc = acc; v.uns = uns; v.addr = a; v.din = d;
        v.exp_rd = erd; v.exp_err = eerr; v.exp_dout = edout;
        tbl.push_back(v);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            step();
        end
    endtask

    // One accepted request followed by output checks one cycle later.
    task automatic op(input string name, input logic we, input logic [1:0] acc, input logic uns,
                      input logic [7:0] a, input logic [31:0] d, input logic erd,
                      input logic eerr, input logic [31:0] edout);
        drive(1'b1, we, acc, uns, a, d);
        step();
        req_valid = 1'b0;
        check({name, ".rd_valid"}, 32'(rd_valid), 32'(erd));
        check({name, ".misalign_err"}, 32'(misalign_err), 32'(eerr));
        check({name, ".Data_out"}, Data_out, edout);
    endtask

    initial begin
        int n;

        // Reset state and clear duration
        step();
        check("rst.Data_out", Data_out, 32'h0);
        check("rst.rd_valid", 32'(rd_valid), 32'h0);
        check("rst.misalign_err", 32'(misalign_err), 32'h0);
        check("rst.req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        wait_ready(n);
        check("clear.cycles", 32'(n), 32'd64);
        op("clr.ld0", 1'b0, W, 1'b0, 8'h00, '0, 1'b1, 1'b0, 32'h0);
        op("clr.ld63", 1'b0, W, 1'b0, 8'hFC, '0, 1'b1, 1'b0, 32'h0);

        // vld we acc uns addr din exp_rd exp_err exp_dout
        add(1, 1, W, 0, 8'h10, 32'hDEADBEEF, 0, 0, 32'h00000000);
        add(1, 0, B, 0, 8'h11, 32'h0,        1, 0, 32'hFFFFFFBE);
        add(1, 0, B, 1, 8'h11, 32'h0,        1, 0, 32'h000000BE);
        add(1, 0, H, 0, 8'h12, 32'h0,        1, 0, 32'hFFFFDEAD);
        add(1, 0, H, 1, 8'h12, 32'h0,        1, 0, 32'h0000DEAD);
        add(1, 0, B, 0, 8'h10, 32'h0,        1, 0, 32'hFFFFFFEF);
        add(1, 1, W, 0, 8'h10, 32'h11223344, 0, 0, 32'hFFFFFFEF);
        add(1, 1, B, 0, 8'h13, 32'hFFFFFF5A, 0, 0, 32'hFFFFFFEF);
        add(1, 0, W, 0, 8'h10, 32'h0,        1, 0, 32'h5A223344);
        add(1, 1, H, 0, 8'h20, 32'hABCD8001, 0, 0, 32'h5A223344);
        add(1, 0, H, 0, 8'h20, 32'h0,        1, 0, 32'hFFFF8001);
        add(1, 0, W, 0, 8'h20, 32'h0,        1, 0, 32'h00008001);
        add(1, 1, H, 0, 8'h22, 32'h00007F00, 0, 0, 32'h00008001);
        add(1, 0, W, 1, 8'h20, 32'h0,        1, 0, 32'h7F008001);
        add(1, 0, H, 0, 8'h22, 32'h0,        1, 0, 32'h00007F00);
        add(1, 0, B, 0, 8'h23, 32'h0,        1, 0, 32'h0000007F);
        add(1, 1, R, 0, 8'h24, 32'hFFFFFFFF, 0, ALIGN_ON, 32'h0000007F);
        add(1, 0, W, 0, 8'h24, 32'h0,        1, 0, 32'h00000000);
        add(1, 0, R, 0, 8'h20, 32'h0,        0, ALIGN_ON, 32'h00000000);
        add(0, 0, W, 0, 8'h20, 32'h0,        0, 0, 32'h00000000);
        add(1, 1, W, 0, 8'h28, 32'h80000000, 0, 0, 32'h00000000);
        add(1, 0, W, 1, 8'h28, 32'h0,        1, 0, 32'h80000000);
        add(1, 1, W, 0, 8'h00, 32'hA0A0A0A0, 0, 0, 32'h80000000);
        add(1, 1, W, 0, 8'h04, 32'hB1B1B1B1, 0, 0, 32'h80000000);
        add(1, 1, W, 0, 8'h08, 32'hC2C2C2C2, 0, 0, 32'h80000000);
        add(1, 0, W, 0, 8'h00, 32'h0,        1, 0, 32'hA0A0A0A0);
        add(1, 0, W, 0, 8'h04, 32'h0,        1, 0, 32'hB1B1B1B1);
        add(1, 0, W, 0, 8'h08, 32'h0,        1, 0, 32'hC2C2C2C2);
        add(1, 0, B, 1, 8'h0A, 32'h0,        1, 0, 32'h000000C2);
        add(1, 0, B, 0, 8'h0B, 32'h0,        1, 0, 32'hFFFFFFC2);

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].we, tbl[i].acc, tbl[i].uns, tbl[i].addr, tbl[i].din);
            step();
            check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].exp_rd));
            check($sformatf("vec%0d.misalign_err", i), 32'(misalign_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d.Data_out", i), Data_out, tbl[i].exp_dout);
            check($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'h1);
        end
        req_valid = 1'b0;

        // Misaligned accesses: rejected with the check enabled, folded to aligned otherwise
        op("mis.st_aligned", 1'b1, W, 1'b0, 8'h30, 32'h0BADF00D, 1'b0, 1'b0, 32'hFFFFFFC2);
        op("mis.ld_w32", 1'b0, W, 1'b0, 8'h32, '0, !ALIGN_ON, ALIGN_ON,
           ALIGN_ON ? 32'hFFFFFFC2 : 32'h0BADF00D);
        op("mis.st_w31", 1'b1, W, 1'b0, 8'h31, 32'h12345678, 1'b0, ALIGN_ON,
           ALIGN_ON ? 32'hFFFFFFC2 : 32'h0BADF00D);
        op("mis.ld_w30", 1'b0, W, 1'b0, 8'h30, '0, 1'b1, 1'b0,
           ALIGN_ON ? 32'h0BADF00D : 32'h12345678);
        op("mis.ld_h33", 1'b0, H, 1'b0, 8'h33, '0, !ALIGN_ON, ALIGN_ON,
           ALIGN_ON ? 32'h0BADF00D : 32'h00001234);

        // Reset wins over a load accepted on the same edge
        drive(1'b1, 1'b0, W, 1'b0, 8'h10, '0);
        rst = 1'b1;
        step();
        req_valid = 1'b0;
        rst = 1'b0;
        check("rstld.rd_valid", 32'(rd_valid), 32'h0);
        check("rstld.Data_out", Data_out, 32'h0);
        check("rstld.req_ready", 32'(req_ready), 32'h0);

        // Reset at clear word 30 restarts the sweep
        for (int i = 0; i < 30; i++) step();
        check("midclr.req_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        check("midclr.cycles", 32'(n), 32'd64);

        op("post.st40", 1'b1, W, 1'b0, 8'h40, 32'h00000055, 1'b0, 1'b0, 32'h0);
        op("post.ld40", 1'b0, W, 1'b0, 8'h40, '0, 1'b1, 1'b0, 32'h00000055);
        op("post.ld10", 1'b0, W, 1'b0, 8'h10, '0, 1'b1, 1'b0, 32'h0);
        op("post.ld41", 1'b0, W, 1'b0, 8'h40, '0, 1'b1, 1'b0, 32'h00000055);
        op("post.ld30", 1'b0, W, 1'b0, 8'h30, '0, 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
